// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer
//
// Builds a 48-bit SD command frame (start bit, transmission bit, command index,
// argument, CRC7, end bit) and shifts it MSB-first onto the CMD line. The CRC7
// (x^7 + x^3 + 1, seed 0) is accumulated bit by bit as frame bits 47..8 leave
// the block, then shifted out itself as bits 7..1. After the end bit the line is
// held idle for GAP_CYCLES cycles before a one-cycle done pulse.
//
// Parameters:
//   GAP_CYCLES     idle cycles after the end bit before done (1..64)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   start          one-cycle request; accepted only in idle
//   command_index  6-bit command index, captured on an accepted start
//   argument       32-bit argument, captured on an accepted start
//   cmd_out        serial CMD data, idles high
//   cmd_oe         CMD output enable, high only while frame bits are driven
//   busy           high whenever not idle
//   done           one-cycle pulse on return to idle after the gap
//
// All outputs are driven straight from flops.

module sd_cmd_serializer #(
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  command_index,
    input  logic [31:0] argument,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    localparam logic [5:0] BitCntStart = 6'd47;
    localparam logic [5:0] GapLoad     = 6'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [5:0]  cnt_q;       // frame bit on the line in SEND, cycles left in GAP
    logic [39:0] shift_q;     // frame bits still to be sent, next one at [39]
    logic [6:0]  crc_q;
    logic        cmd_out_q;
    logic        cmd_oe_q;
    logic        busy_q;
    logic        done_q;

    // Head of the frame: bits 47..8 (start, transmission, index, argument).
    logic [39:0] frame_head;

    assign frame_head = {2'b01, command_index, argument};

    // One serial CRC7 step: shift left, fold the feedback into taps x^3 and x^0.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // Bit 47 goes on the line right away; the rest waits in
                        // the shift register so later input changes are harmless.
                        state_q   <= StSend;
                        cnt_q     <= BitCntStart;
                        cmd_out_q <= frame_head[39];
                        shift_q   <= {frame_head[38:0], 1'b0};
                        crc_q     <= crc7_step(7'd0, frame_head[39]);
                        cmd_oe_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                StSend: begin
                    if (cnt_q == 6'd0) begin
                        // End bit has been on the line for its cycle.
                        state_q   <= StGap;
                        cnt_q     <= GapLoad;
                        cmd_out_q <= 1'b1;
                        cmd_oe_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                        // Next bit index is cnt_q - 1.
                        if (cnt_q > 6'd8) begin
                            cmd_out_q <= shift_q[39];
                            shift_q   <= {shift_q[38:0], 1'b0};
                            crc_q     <= crc7_step(crc_q, shift_q[39]);
                        end else if (cnt_q > 6'd1) begin
                            cmd_out_q <= crc_q[6];
                            crc_q     <= {crc_q[5:0], 1'b0};
                        end else begin
                            cmd_out_q <= 1'b1;
                        end
                    end
                end

                StGap: begin
                    if (cnt_q == 6'd0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        crc_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    crc_q     <= '0;
                    cmd_out_q <= 1'b1;
                    cmd_oe_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_out = cmd_out_q;
    assign cmd_oe  = cmd_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sd_cmd_serializer.sv
module tb_sd_cmd_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  command_index = '0;
    logic [31:0] argument = '0;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
        logic        chg_arg;
    } vec_t;

    vec_t vecs [4];

    sd_cmd_serializer #(
        .GAP_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .command_index (command_index),
        .argument      (argument),
        .cmd_out       (cmd_out),
        .cmd_oe        (cmd_oe),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive a start pulse sampled at the next rising edge (E0).
    task automatic apply_start(input logic [5:0] idx, input logic [31:0] arg);
        @(negedge clk);
        start         = 1'b1;
        command_index = idx;
        argument      = arg;
    endtask

    // Samples after E0..E56. x1/x2: edges at which an extra start is sampled.
    // chain: request a new frame sampled at E57.
    task automatic observe(input string name, input logic [47:0] exp, input logic chg,
                           input int x1, input int x2, input logic chain,
                           input logic [5:0] c_idx, input logic [31:0] c_arg);
        logic [47:0] got;
        int oe_cnt, busy_cnt, done_at, done_cnt, idle_err;
        got = '0;
        oe_cnt = 0; busy_cnt = 0; done_at = -1; done_cnt = 0; idle_err = 0;
        for (int k = 0; k <= 56; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k + 1 == x1 || k + 1 == x2) start = 1'b1;
            if (chg && k == 5) begin
                argument      = 32'hFFFF_FFFF;
                command_index = 6'h3F;
            end
            if (chain && k == 56) begin
                start         = 1'b1;
                command_index = c_idx;
                argument      = c_arg;
            end
            if (k < 48) got = {got[46:0], cmd_out};
            else if (cmd_out !== 1'b1) idle_err++;
            if (cmd_oe === 1'b1) oe_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check({name, " frame"}, 64'(got), 64'(exp));
        check({name, " oe cycles"}, 64'(oe_cnt), 64'd48);
        check({name, " busy cycles"}, 64'(busy_cnt), 64'd56);
        check({name, " done edge"}, 64'(done_at), 64'd56);
        check({name, " done count"}, 64'(done_cnt), 64'd1);
        check({name, " gap line high"}, 64'(idle_err), 64'd0);
    endtask

    initial begin
        int oe_seen, busy_seen, done_seen;

        vecs[0] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_0000_0000_95, chg_arg: 1'b0};
        vecs[1] = '{idx: 6'd8,  arg: 32'h0000_01AA, frame: 48'h48_0000_01AA_87, chg_arg: 1'b0};
        vecs[2] = '{idx: 6'd55, arg: 32'h0000_0000, frame: 48'h77_0000_0000_65, chg_arg: 1'b1};
        vecs[3] = '{idx: 6'd17, arg: 32'h0000_0000, frame: 48'h51_0000_0000_55, chg_arg: 1'b0};

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cmd_out", 64'(cmd_out), 64'd1);
        check("reset cmd_oe", 64'(cmd_oe), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 4; i++) begin
            apply_start(vecs[i].idx, vecs[i].arg);
            observe($sformatf("vec%0d", i), vecs[i].frame, vecs[i].chg_arg, -1, -1,
                    1'b0, 6'd0, 32'd0);
        end

        // Starts at E10 (SEND) and E50 (GAP) ignored; start at E57 chains.
        apply_start(6'd8, 32'h0000_01AA);
        observe("ignored", 48'h48_0000_01AA_87, 1'b0, 10, 50, 1'b1, 6'd55, 32'd0);
        observe("b2b", 48'h77_0000_0000_65, 1'b0, -1, -1, 1'b0, 6'd0, 32'd0);

        // Reset sampled at E20 of a CMD17 frame.
        apply_start(6'd17, 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 19) reset = 1'b1;
        end
        @(negedge clk);
        check("midrst cmd_oe", 64'(cmd_oe), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst cmd_out", 64'(cmd_out), 64'd1);
        check("midrst done", 64'(done), 64'd0);
        reset = 1'b0;
        oe_seen = 0; done_seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (cmd_oe === 1'b1) oe_seen++;
            if (done === 1'b1) done_seen++;
        end
        check("midrst later oe", 64'(oe_seen), 64'd0);
        check("midrst later done", 64'(done_seen), 64'd0);
        apply_start(6'd17, 32'd0);
        observe("after rst", 48'h51_0000_0000_55, 1'b0, -1, -1, 1'b0, 6'd0, 32'd0);

        // Reset and start in the same cycle.
        @(negedge clk);
        reset         = 1'b1;
        start         = 1'b1;
        command_index = 6'd8;
        argument      = 32'h0000_01AA;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("simul busy", 64'(busy), 64'd0);
        check("simul cmd_oe", 64'(cmd_oe), 64'd0);
        oe_seen = 0; busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (cmd_oe === 1'b1) oe_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        check("simul later oe", 64'(oe_seen), 64'd0);
        check("simul later busy", 64'(busy_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_cmd_serializer.md
# sd_cmd_serializer

Downstream stage of the SD host command-start detector: on a one-cycle `start` pulse it captures the 6-bit command index and 32-bit argument, builds the 48-bit SD command frame with CRC7, and shifts it MSB-first onto the CMD line. After the frame it enforces an 8-cycle Ncc gap, then reports completion. The SD host uses it as the sole driver of the CMD output enable.

## Interface
- `GAP_CYCLES`, 8: CMD-line idle cycles after the end bit before `done`.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request pulse from the start detector.
- `command_index`  input  6  command index; sampled only when `start` is accepted.
- `argument`  input  32  command argument; sampled with `command_index`.
- `cmd_out`  output  1  serial CMD data; idles at 1.
- `cmd_oe`  output  1  CMD output enable; high only while frame bits are driven.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when frame and gap are complete.

## Operation
- Frame, bit 47 down to 0: start bit 0, transmission bit 1, `command_index[5:0]`, `argument[31:0]`, CRC7[6:0], end bit 1.
- CRC7 polynomial x^7+x^3+1, initial value 0. Computed serially over frame bits 47..8 as they are shifted out. Bits 7..1 shift out the CRC register MSB-first. No precomputation.
- FSM states:
  - IDLE: `cmd_out`=1, `cmd_oe`=0, `busy`=0. `start`=1 latches the inputs and moves to SEND.
  - SEND: 48 cycles, 6-bit bit counter runs 47 down to 0. At counter 0, go to GAP.
  - GAP: `GAP_CYCLES` cycles with `cmd_oe`=0 and `cmd_out`=1, then go to IDLE with `done`=1 for that first IDLE cycle.
- `start` during SEND or GAP is ignored; no queuing. Input changes after capture do not affect the frame in flight.
- All outputs are registered.
- Reset values: state IDLE, `cmd_out`=1, `cmd_oe`=0, `busy`=0, `done`=0, CRC=0, counter=0.
- Reset asserted mid-SEND or mid-GAP: the next cycle is IDLE with reset values. No `done`, no partial-frame completion.
- Reset and `start` in the same cycle: reset wins and `start` is dropped.

## Timing
- `start` sampled high at edge E0 in IDLE. After E0, `cmd_out` = bit 47 (0), `cmd_oe`=1, `busy`=1.
- After E1..E47, `cmd_out` carries bits 46..0, one bit per cycle. The end bit is visible after E47.
- After E48, `cmd_oe`=0 and `cmd_out`=1. This gap state holds through the cycles following E48..E55.
- After E56, `busy`=0 and `done`=1 for exactly one cycle. A `start` sampled at E57 is accepted, giving back-to-back frames 57 cycles apart.
- Latency from accepted `start` to first driven bit: 1 cycle.

## Test plan
- Reset check: hold `reset` 2 cycles -> `cmd_out`=1, `cmd_oe`=0, `busy`=0, `done`=0. Then pulse `start` with index 0, argument 0 -> captured frame 0x40_00000000_95 (CRC7 0x4A).
- CMD8: index 8, argument 0x000001AA -> frame 0x48_000001AA_87. `cmd_oe` high for exactly 48 cycles, `done` pulses at E56+1.
- CMD55: index 55, argument 0 -> frame 0x77_00000000_65. Change `argument` to 0xFFFFFFFF mid-frame -> frame unchanged.
- Ignored start: pulse `start` at E10 and again in a GAP cycle (E50) -> only one frame and one `done`. Then `start` at E57 -> second frame begins the next cycle.
- Reset mid-operation: assert `reset` at E20 of a CMD17 (index 17, argument 0) frame -> next cycle IDLE, `cmd_oe`=0, no `done`. A new CMD17 then yields 0x51_00000000_55.
- Simultaneous events: `reset` and `start` in the same cycle -> stays IDLE, `busy`=0, `cmd_oe` never asserts.
